// File: rtl/arp_pkg.sv
// Shared types and constants for the ARP resolver control block.
package arp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND_REQ,
    WAIT_REQ_DONE,
    WAIT_REPLY,
    SEND_RPL,
    WAIT_RPL_DONE
  } arp_state_t;

  localparam logic        ARP_TYPE_REQ  = 1'b0;
  localparam logic        ARP_TYPE_RPL  = 1'b1;
  localparam logic [47:0] ARP_BCAST_MAC = 48'hff_ff_ff_ff_ff_ff;

endpackage

// File: rtl/arp_retry_timer.sv
// Per-attempt reply timeout: counts while run is high, holds otherwise,
// and saturates at the expiry value instead of wrapping.
module arp_retry_timer #(
  parameter int TIMEOUT_CYCLES = 125_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (run && cnt != LAST) cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/arp_resolver.sv
// User-side ARP control: answers incoming requests automatically and resolves
// a target IP to a peer MAC with broadcast requests, timeout and retry.
module arp_resolver
  import arp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 125_000_000,
  parameter int MAX_RETRY      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        resolve_req,
  input  logic [31:0] resolve_ip,
  input  logic        arp_rx_done,
  input  logic        arp_rx_type,
  input  logic [47:0] src_mac,
  input  logic [31:0] src_ip,
  input  logic        tx_done,
  output logic        arp_tx_en,
  output logic        arp_tx_type,
  output logic [47:0] des_mac,
  output logic [31:0] des_ip,
  output logic [47:0] peer_mac,
  output logic [31:0] peer_ip,
  output logic        peer_valid,
  output logic        resolve_busy,
  output logic        resolve_fail
);

  localparam int AW = $clog2(MAX_RETRY + 1);
  localparam logic [AW-1:0] MAX_ATT = AW'(MAX_RETRY);

  arp_state_t  state, next, ret_state;
  logic        rpl_pend;
  logic [47:0] rpl_mac;
  logic [31:0] rpl_ip;
  logic [31:0] target_ip;
  logic [AW-1:0] attempt;
  logic        busy, match, expired, timer_clr, lookup_done, fail;

  assign match = arp_rx_done && (arp_rx_type == ARP_TYPE_RPL) && (src_ip == target_ip);

  arp_retry_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .run     (state == WAIT_REPLY),
    .expired (expired)
  );

  // A matching reply outranks both reply service and timer expiry.
  always_comb begin
    next        = state;
    timer_clr   = 1'b0;
    lookup_done = 1'b0;
    fail        = 1'b0;
    case (state)
      IDLE:          if (rpl_pend) next = SEND_RPL;
                     else if (busy) next = SEND_REQ;
      SEND_REQ:      next = WAIT_REQ_DONE;
      WAIT_REQ_DONE: if (tx_done) begin
                       next      = WAIT_REPLY;
                       timer_clr = 1'b1;
                     end
      WAIT_REPLY:    if (match) begin
                       next        = IDLE;
                       lookup_done = 1'b1;
                     end else if (rpl_pend) begin
                       next = SEND_RPL;
                     end else if (expired) begin
                       if (attempt < MAX_ATT) next = SEND_REQ;
                       else begin
                         next        = IDLE;
                         fail        = 1'b1;
                         lookup_done = 1'b1;
                       end
                     end
      SEND_RPL:      next = WAIT_RPL_DONE;
      WAIT_RPL_DONE: if (tx_done) next = ret_state;
      default:       next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ret_state   <= IDLE;
      rpl_pend    <= 1'b0;
      rpl_mac     <= '0;
      rpl_ip      <= '0;
      target_ip   <= '0;
      attempt     <= '0;
      busy        <= 1'b0;
      arp_tx_type <= ARP_TYPE_REQ;
      des_mac     <= '0;
      des_ip      <= '0;
      peer_mac    <= '0;
      peer_ip     <= '0;
      peer_valid  <= 1'b0;
    end else begin
      state <= next;
      // Frame fields are captured on entry so they hold until tx_done.
      if (next == SEND_RPL) begin
        ret_state   <= state;
        arp_tx_type <= ARP_TYPE_RPL;
        des_mac     <= rpl_mac;
        des_ip      <= rpl_ip;
      end else if (next == SEND_REQ) begin
        arp_tx_type <= ARP_TYPE_REQ;
        des_mac     <= ARP_BCAST_MAC;
        des_ip      <= target_ip;
      end
      if (arp_rx_done && arp_rx_type == ARP_TYPE_REQ) begin
        rpl_pend <= 1'b1;
        rpl_mac  <= src_mac;
        rpl_ip   <= src_ip;
      end else if (next == SEND_RPL) begin
        rpl_pend <= 1'b0;
      end
      if (state == SEND_REQ) attempt <= attempt + 1'b1;
      if (lookup_done) begin
        busy <= 1'b0;
      end else if (resolve_req && !busy) begin
        busy      <= 1'b1;
        target_ip <= resolve_ip;
        attempt   <= '0;
        if (resolve_ip != peer_ip) peer_valid <= 1'b0;
      end
      if (match) begin
        peer_mac   <= src_mac;
        peer_ip    <= src_ip;
        peer_valid <= 1'b1;
      end
    end
  end

  assign arp_tx_en    = (state == SEND_REQ) || (state == SEND_RPL);
  assign resolve_busy = busy;
  assign resolve_fail = fail;

endmodule

// File: tb/tb_arp_resolver.sv
// Directed-random bench for arp_resolver: expected frame timing and contents
// come from event arithmetic on the documented cycle rules.
module tb_arp_resolver;
  import arp_pkg::*;

  localparam int TO = 100;
  localparam int MR = 3;

  logic        clk = 1'b0, rst = 1'b1;
  logic        resolve_req = 1'b0, arp_rx_done = 1'b0, arp_rx_type = 1'b0, tx_done = 1'b0;
  logic [31:0] resolve_ip = '0, src_ip = '0;
  logic [47:0] src_mac = '0;
  logic        arp_tx_en, arp_tx_type, peer_valid, resolve_busy, resolve_fail;
  logic [47:0] des_mac, peer_mac;
  logic [31:0] des_ip, peer_ip;

  arp_resolver #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .resolve_req(resolve_req), .resolve_ip(resolve_ip),
    .arp_rx_done(arp_rx_done), .arp_rx_type(arp_rx_type), .src_mac(src_mac),
    .src_ip(src_ip), .tx_done(tx_done), .arp_tx_en(arp_tx_en),
    .arp_tx_type(arp_tx_type), .des_mac(des_mac), .des_ip(des_ip),
    .peer_mac(peer_mac), .peer_ip(peer_ip), .peer_valid(peer_valid),
    .resolve_busy(resolve_busy), .resolve_fail(resolve_fail)
  );

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int c; logic t; logic [47:0] m; logic [31:0] ip;} tx_rec_t;
  tx_rec_t tx_q[$];
  int      fail_q[$];

  always @(negedge clk) begin
    if (arp_tx_en === 1'b1) tx_q.push_back('{cyc, arp_tx_type, des_mac, des_ip});
    if (resolve_fail === 1'b1) fail_q.push_back(cyc);
  end

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic req(input logic [31:0] ip);
    resolve_req = 1'b1; resolve_ip = ip;
    tick();
    resolve_req = 1'b0;
  endtask

  task automatic send_rx(input logic t, input logic [47:0] m, input logic [31:0] ip);
    arp_rx_done = 1'b1; arp_rx_type = t; src_mac = m; src_ip = ip;
    tick();
    arp_rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic expect_tx(input string tag, input int ec, input logic et,
                           input logic [47:0] em, input logic [31:0] eip, input int budget);
    int k = 0;
    tx_rec_t r;
    while (tx_q.size() == 0 && k < budget) begin tick(); k++; end
    if (tx_q.size() == 0) begin
      n_cmp++; n_err++;
      $error("FAIL %s_timeout: no arp_tx_en within %0d cycles, expected at cycle %0d", tag, budget, ec);
    end else begin
      r = tx_q.pop_front();
      chk({tag, "_cycle"}, 96'(r.c), 96'(ec));
      chk({tag, "_type"},  96'(r.t), 96'(et));
      chk({tag, "_mac"},   96'(r.m), 96'(em));
      chk({tag, "_ip"},    96'(r.ip), 96'(eip));
    end
  endtask

  // Frame fields must hold and no second start pulse may appear before tx_done.
  task automatic hold_check(input string tag, input logic et, input logic [47:0] em,
                            input logic [31:0] eip, input int n);
    repeat (n) tick();
    chk({tag, "_hold_type"}, 96'(arp_tx_type), 96'(et));
    chk({tag, "_hold_mac"},  96'(des_mac), 96'(em));
    chk({tag, "_hold_ip"},   96'(des_ip), 96'(eip));
    chk({tag, "_hold_noen"}, 96'(tx_q.size()), 96'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, t, rr, dd, k;
    logic [31:0] ip, ip2;
    logic [47:0] mac, mac2;

    // Reset state
    idle(3);
    chk("rst_tx_en", 96'(arp_tx_en), 96'(0));
    chk("rst_tx_type", 96'(arp_tx_type), 96'(0));
    chk("rst_des_mac", 96'(des_mac), 96'(0));
    chk("rst_des_ip", 96'(des_ip), 96'(0));
    chk("rst_peer", 96'({peer_mac, peer_ip}), 96'(0));
    chk("rst_flags", 96'({peer_valid, resolve_busy, resolve_fail}), 96'(0));
    rst = 1'b0;
    idle(2);

    // Automatic reply: fixed vector then a random one
    for (int i = 0; i < 2; i++) begin
      mac = (i == 0) ? 48'h0a0b0c0d0e0f : {16'($urandom), 32'($urandom)};
      ip  = (i == 0) ? 32'hc0a80166 : 32'($urandom);
      n0 = cyc;
      send_rx(ARP_TYPE_REQ, mac, ip);
      expect_tx("rpl", n0 + 2, ARP_TYPE_RPL, mac, ip, 10);
      hold_check("rpl", ARP_TYPE_RPL, mac, ip, int'($urandom_range(2, 8)));
      pulse_tx_done();
      idle(5);
      chk("rpl_single", 96'(tx_q.size()), 96'(0));
    end

    // Lookup success, with an ignored second request and a non-matching reply
    ip  = 32'hc0a80166;
    mac = {16'($urandom), 32'($urandom)};
    n0 = cyc;
    req(ip);
    chk("busy_rise", 96'(resolve_busy), 96'(1));
    expect_tx("req", n0 + 2, ARP_TYPE_REQ, ARP_BCAST_MAC, ip, 10);
    hold_check("req", ARP_TYPE_REQ, ARP_BCAST_MAC, ip, int'($urandom_range(2, 8)));
    t = cyc;
    pulse_tx_done();
    idle(5);
    req(ip ^ 32'h1);
    send_rx(ARP_TYPE_RPL, {16'($urandom), 32'($urandom)}, ip ^ 32'h100);
    chk("nomatch_valid", 96'(peer_valid), 96'(0));
    chk("nomatch_busy", 96'(resolve_busy), 96'(1));
    while (cyc < t + 40) tick();
    send_rx(ARP_TYPE_RPL, mac, ip);
    chk("ok_valid", 96'(peer_valid), 96'(1));
    chk("ok_mac", 96'(peer_mac), 96'(mac));
    chk("ok_ip", 96'(peer_ip), 96'(ip));
    chk("ok_busy", 96'(resolve_busy), 96'(0));
    idle(120);
    chk("ok_no_retry", 96'(tx_q.size()), 96'(0));
    chk("ok_no_fail", 96'(fail_q.size()), 96'(0));

    // Retry to exhaustion; a new IP clears peer_valid
    ip2 = 32'($urandom) | 32'h1;
    if (ip2 == ip) ip2 = ip ^ 32'h80;
    n0 = cyc;
    req(ip2);
    chk("pv_clear", 96'(peer_valid), 96'(0));
    t = n0 + 2;
    for (int a = 0; a < MR; a++) begin
      expect_tx($sformatf("try%0d", a), t, ARP_TYPE_REQ, ARP_BCAST_MAC, ip2, 150);
      hold_check("try", ARP_TYPE_REQ, ARP_BCAST_MAC, ip2, int'($urandom_range(2, 8)));
      n0 = cyc;
      pulse_tx_done();
      t = n0 + TO + 1;
    end
    k = 0;
    while (fail_q.size() == 0 && k < 150) begin tick(); k++; end
    if (fail_q.size() == 0) begin
      n_cmp++; n_err++;
      $error("FAIL fail_timeout: no resolve_fail within 150 cycles");
    end else begin
      chk("fail_cycle", 96'(fail_q.pop_front()), 96'(n0 + TO));
    end
    idle(5);
    chk("fail_single", 96'(fail_q.size()), 96'(0));
    chk("fail_busy", 96'(resolve_busy), 96'(0));
    chk("fail_no_more_tx", 96'(tx_q.size()), 96'(0));

    // Preemption: incoming request serviced mid-wait, timer frozen while away
    ip = 32'($urandom);
    n0 = cyc;
    req(ip);
    expect_tx("pre_req1", n0 + 2, ARP_TYPE_REQ, ARP_BCAST_MAC, ip, 10);
    idle(int'($urandom_range(1, 6)));
    t = cyc;
    pulse_tx_done();
    while (cyc < t + int'($urandom_range(10, 60))) tick();
    rr = cyc;
    mac2 = {16'($urandom), 32'($urandom)};
    ip2  = 32'($urandom);
    send_rx(ARP_TYPE_REQ, mac2, ip2);
    expect_tx("pre_rpl", rr + 2, ARP_TYPE_RPL, mac2, ip2, 10);
    hold_check("pre_rpl", ARP_TYPE_RPL, mac2, ip2, int'($urandom_range(3, 12)));
    dd = cyc;
    pulse_tx_done();
    expect_tx("pre_req2", t + TO + 1 + (dd - rr - 1), ARP_TYPE_REQ, ARP_BCAST_MAC, ip, 150);
    idle(3);
    pulse_tx_done();
    idle(5);
    mac = {16'($urandom), 32'($urandom)};
    send_rx(ARP_TYPE_RPL, mac, ip);
    chk("pre_mac", 96'(peer_mac), 96'(mac));
    chk("pre_done", 96'({peer_valid, resolve_busy}), 96'(2'b10));

    // Request and lookup in the same cycle, then reply racing the final expiry
    ip   = 32'($urandom) ^ 32'h5a5a0000;
    mac2 = {16'($urandom), 32'($urandom)};
    ip2  = 32'($urandom);
    n0 = cyc;
    resolve_req = 1'b1; resolve_ip = ip;
    send_rx(ARP_TYPE_REQ, mac2, ip2);
    resolve_req = 1'b0;
    expect_tx("both_rpl", n0 + 2, ARP_TYPE_RPL, mac2, ip2, 10);
    idle(int'($urandom_range(1, 6)));
    dd = cyc;
    pulse_tx_done();
    expect_tx("both_req", dd + 2, ARP_TYPE_REQ, ARP_BCAST_MAC, ip, 10);
    for (int a = 1; a < MR; a++) begin
      idle(2);
      t = cyc;
      pulse_tx_done();
      expect_tx($sformatf("race_try%0d", a), t + TO + 1, ARP_TYPE_REQ, ARP_BCAST_MAC, ip, 150);
    end
    idle(2);
    t = cyc;
    pulse_tx_done();
    while (cyc < t + TO) tick();
    mac = {16'($urandom), 32'($urandom)};
    send_rx(ARP_TYPE_RPL, mac, ip);
    chk("race_valid", 96'(peer_valid), 96'(1));
    chk("race_mac", 96'(peer_mac), 96'(mac));
    chk("race_busy", 96'(resolve_busy), 96'(0));
    idle(110);
    chk("race_no_fail", 96'(fail_q.size()), 96'(0));
    chk("race_no_tx", 96'(tx_q.size()), 96'(0));

    // Reset while waiting for the engine, then a stale tx_done
    ip = 32'($urandom);
    n0 = cyc;
    req(ip);
    expect_tx("rst_req", n0 + 2, ARP_TYPE_REQ, ARP_BCAST_MAC, ip, 10);
    idle(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_des", 96'({des_mac, des_ip}), 96'(0));
    chk("mid_rst_peer", 96'({peer_mac, peer_ip}), 96'(0));
    chk("mid_rst_flags", 96'({arp_tx_en, arp_tx_type, peer_valid, resolve_busy, resolve_fail}), 96'(0));
    pulse_tx_done();
    idle(10);
    chk("stale_no_tx", 96'(tx_q.size()), 96'(0));
    chk("stale_busy", 96'(resolve_busy), 96'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
